// File: rtl/intc_sched_if.sv
// Handshake and bus bundle for the interrupt scheduler.
// Ports (slave = scheduler side):
//   done, mask_we, mask_wdata, iack, eoi : driven by peripherals / CPU
//   irq, EAddr, active_id, pending, busy : driven by the scheduler
interface intc_sched_if #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = $clog2(N_SRC)
);
    logic [N_SRC-1:0] done;
    logic             mask_we;
    logic [N_SRC-1:0] mask_wdata;
    logic             iack;
    logic             eoi;
    logic             irq;
    logic [31:0]      EAddr;
    logic [ID_W-1:0]  active_id;
    logic [N_SRC-1:0] pending;
    logic             busy;

    modport master (
        output done, mask_we, mask_wdata, iack, eoi,
        input  irq, EAddr, active_id, pending, busy
    );

    modport slave (
        input  done, mask_we, mask_wdata, iack, eoi,
        output irq, EAddr, active_id, pending, busy
    );
endinterface

// File: rtl/intc_sched.sv
// Interrupt scheduling controller: captures done-flag rising edges into
// pending bits, masks them, picks one winner and runs the irq/iack/eoi
// handshake with the CPU, presenting the winner's vector on EAddr.
// One interrupt is serviced at a time; no pre-emption.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : intc_sched_if.slave (done, mask write, iack, eoi in;
//          irq, EAddr, active_id, pending, busy out, all registered)
// Build option: define INTC_SCHED_RR_EN for round-robin arbitration
// (search starts after the last acknowledged source); otherwise fixed
// priority with source 0 highest.
module intc_sched #(
    parameter int unsigned N_SRC    = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0100,
    parameter int unsigned ID_W     = $clog2(N_SRC)
) (
    input  logic        clk,
    input  logic        rst,
    intc_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [N_SRC-1:0] done_d_q;
    logic [N_SRC-1:0] pending_q, pending_n;
    logic [N_SRC-1:0] mask_q;
    logic             irq_q, irq_n;
    logic [31:0]      eaddr_q, eaddr_n;
    logic [ID_W-1:0]  id_q, id_n;
    logic             busy_q, busy_n;

    logic [N_SRC-1:0] rise_c;
    logic [N_SRC-1:0] req_c;
    logic [N_SRC-1:0] clr_c;
    logic [ID_W-1:0]  win_c;
    logic             win_vld_c;

`ifdef INTC_SCHED_RR_EN
    logic [ID_W-1:0]  ptr_q, ptr_n;
`endif

    assign rise_c = bus.done & ~done_d_q;
    assign req_c  = pending_q & ~mask_q;

    // Winner selection: first requesting source in search order
    always_comb begin
        win_c     = '0;
        win_vld_c = 1'b0;
`ifdef INTC_SCHED_RR_EN
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!win_vld_c && req_c[ID_W'((32'(ptr_q) + 32'd1 + k) % N_SRC)]) begin
                win_vld_c = 1'b1;
                win_c     = ID_W'((32'(ptr_q) + 32'd1 + k) % N_SRC);
            end
        end
`else
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!win_vld_c && req_c[ID_W'(k)]) begin
                win_vld_c = 1'b1;
                win_c     = ID_W'(k);
            end
        end
`endif
    end

    // Next-state and next-output logic for the handshake FSM
    always_comb begin
        state_n = state_q;
        irq_n   = irq_q;
        eaddr_n = eaddr_q;
        id_n    = id_q;
        clr_c   = '0;
`ifdef INTC_SCHED_RR_EN
        ptr_n   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                irq_n   = 1'b0;
                eaddr_n = '0;
                if (win_vld_c) begin
                    state_n = S_ASSERT;
                    irq_n   = 1'b1;
                    id_n    = win_c;
                    eaddr_n = VEC_BASE + (32'(win_c) << 2);
                end
            end
            S_ASSERT: begin
                irq_n = 1'b1;
                // iack takes precedence over a simultaneous eoi
                if (bus.iack) begin
                    state_n      = S_SERVICE;
                    irq_n        = 1'b0;
                    clr_c[id_q]  = 1'b1;
`ifdef INTC_SCHED_RR_EN
                    ptr_n        = id_q;
`endif
                end
            end
            S_SERVICE: begin
                irq_n = 1'b0;
                if (bus.eoi) begin
                    state_n = S_IDLE;
                    eaddr_n = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                irq_n   = 1'b0;
                eaddr_n = '0;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // A rise in the same cycle as the clear wins, so re-triggers are not lost
    assign pending_n = (pending_q & ~clr_c) | rise_c;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            done_d_q  <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            eaddr_q   <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
`ifdef INTC_SCHED_RR_EN
            ptr_q     <= ID_W'(N_SRC - 1);
`endif
        end else begin
            state_q   <= state_n;
            done_d_q  <= bus.done;
            pending_q <= pending_n;
            if (bus.mask_we) begin
                mask_q <= bus.mask_wdata;
            end
            irq_q     <= irq_n;
            eaddr_q   <= eaddr_n;
            id_q      <= id_n;
            busy_q    <= busy_n;
`ifdef INTC_SCHED_RR_EN
            ptr_q     <= ptr_n;
`endif
        end
    end

    assign bus.irq       = irq_q;
    assign bus.EAddr     = eaddr_q;
    assign bus.active_id = id_q;
    assign bus.pending   = pending_q;
    assign bus.busy      = busy_q;

endmodule
